pulse_extend_mc: RTL and testbench

- Multi-channel, parametrised pulse extender for control/timing paths.
- Each channel delays its input by a fixed pipeline depth, then widens every pulse by a runtime-programmable left margin and right margin.
- Adds a per-channel one-shot mode, channel count/width parametrisation, and glitch-free (shadowed) configuration update.
- Sits between timing-pulse sources and gated consumers, where a window must open before and close after an event.

---
 rtl/pulse_extend_mc.sv | 114 +++++++++++
 tb/tb_pulse_extend_mc.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_extend_mc.sv
`timescale 1ns/1ps
// Multi-channel pulse extender: delays each input by DLY-Le cycles, then stretches each pulse by Le+R.
// Mode 0 retriggers/merges windows; mode 1 emits one fixed-width shot per idle rising edge.
module pulse_extend_mc #(
  parameter int CH    = 4,
  parameter int DLY   = 64,
  parameter int CNT_W = 16,
  parameter int DEF_L = 0,
  parameter int DEF_R = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       pulse_in,
  input  logic [CH*CNT_W-1:0] ext_l,
  input  logic [CH*CNT_W-1:0] ext_r,
  input  logic [CH-1:0]       mode,
  input  logic                cfg_load,
  output logic [CH-1:0]       cfg_pending,
  output logic [CH-1:0]       pulse_out
);

  localparam int TW = $clog2(DLY + 1);
  localparam logic [CNT_W:0]   DLY_C = (CNT_W+1)'(DLY);
  localparam logic [CNT_W:0]   LE0   = (DEF_L > DLY) ? DLY_C : (CNT_W+1)'(DEF_L);
  localparam logic [CNT_W-1:0] SH_L0 = CNT_W'(DEF_L);
  localparam logic [CNT_W-1:0] R0    = CNT_W'(DEF_R);
  localparam logic [CNT_W:0]   ONE   = (CNT_W+1)'(1);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [DLY-1:0]   dl;
    logic [DLY:0]     taps;
    logic [TW-1:0]    tap;
    logic [CNT_W:0]   le;
    logic [CNT_W:0]   le_sh;
    logic [CNT_W:0]   cnt;
    logic [CNT_W:0]   cnt_nxt;
    logic [CNT_W-1:0] r;
    logic [CNT_W-1:0] sh_l;
    logic [CNT_W-1:0] sh_r;
    logic             md;
    logic             sh_m;
    logic             pend;
    logic             d;
    logic             d_q;
    logic             out_q;
    logic             out_nxt;
    logic             trig;
    logic             idle;
    logic             apply;

    // taps[j] is pulse_in delayed by j cycles; taps[0] is the live input
    assign taps  = {dl, pulse_in[c]};
    assign tap   = TW'(DLY_C - le);
    assign d     = taps[tap];
    assign le_sh = ({1'b0, sh_l} > DLY_C) ? DLY_C : {1'b0, sh_l};
    assign idle  = (cnt == '0) && !out_q;
    // Swap timing only when nothing is in flight so no window is ever cut or split
    assign apply = pend && idle && (dl == '0);

    always_comb begin
      trig    = 1'b0;
      cnt_nxt = cnt;
      out_nxt = 1'b0;
      if (md) begin
        trig = d && !d_q && idle;
      end else begin
        trig = d;
      end
      if (trig) begin
        cnt_nxt = le + {1'b0, r};
      end else if (cnt != '0) begin
        cnt_nxt = cnt - ONE;
      end
      out_nxt = trig || (cnt != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dl    <= '0;
        cnt   <= '0;
        out_q <= 1'b0;
        d_q   <= 1'b0;
        le    <= LE0;
        r     <= R0;
        md    <= 1'b0;
        sh_l  <= SH_L0;
        sh_r  <= R0;
        sh_m  <= 1'b0;
        pend  <= 1'b0;
      end else begin
        dl    <= taps[DLY-1:0];
        cnt   <= cnt_nxt;
        out_q <= out_nxt;
        d_q   <= d;
        if (apply) begin
          le <= le_sh;
          r  <= sh_r;
          md <= sh_m;
        end
        // A strobe coinciding with an apply is captured and stays pending
        if (cfg_load) begin
          sh_l <= ext_l[c*CNT_W +: CNT_W];
          sh_r <= ext_r[c*CNT_W +: CNT_W];
          sh_m <= mode[c];
        end
        pend <= cfg_load || (pend && !apply);
      end
    end

    assign pulse_out[c]   = out_q;
    assign cfg_pending[c] = pend;
  end

endmodule

// File: tb/tb_pulse_extend_mc.sv
`timescale 1ns/1ps
// Directed bench for pulse_extend_mc (CH=4, DLY=64, CNT_W=16, defaults 0); channel 0 is observed in detail.
module tb_pulse_extend_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  pulse_in;
  logic [63:0] ext_l;
  logic [63:0] ext_r;
  logic [3:0]  mode;
  logic        cfg_load;
  logic [3:0]  cfg_pending;
  logic [3:0]  pulse_out;

  int checks = 0;
  int passed = 0;

  pulse_extend_mc #(.CH(4), .DLY(64), .CNT_W(16), .DEF_L(0), .DEF_R(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .pulse_in    (pulse_in),
    .ext_l       (ext_l),
    .ext_r       (ext_r),
    .mode        (mode),
    .cfg_load    (cfg_load),
    .cfg_pending (cfg_pending),
    .pulse_out   (pulse_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs n cycles driving channel 0 from pat and optionally strobing cfg_load at cfg_at.
  // Cycle k observes pulse_out first, then drives the inputs sampled at the end of cycle k.
  task automatic run_ch0(input int n, input logic [255:0] pat, input int cfg_at,
                         output int first, output int last, output int rises,
                         output int cnt, output int others, output int pcnt, output int pclr);
    logic prev;
    prev = 1'b0;
    first = -1; last = -1; rises = 0; cnt = 0; others = 0; pcnt = 0; pclr = -1;
    for (int k = 0; k < n; k++) begin
      if (pulse_out[0]) begin
        if (!prev) rises++;
        if (first < 0) first = k;
        last = k;
        cnt++;
      end
      if (pulse_out[3:1] != 3'b000) others++;
      if (cfg_pending[0]) pcnt++;
      if (cfg_at >= 0 && k > cfg_at && pclr < 0 && !cfg_pending[0]) pclr = k;
      prev = pulse_out[0];
      pulse_in = {3'b000, (k < 256) ? pat[k[7:0]] : 1'b0};
      cfg_load = (k == cfg_at);
      step();
    end
    pulse_in = '0;
    cfg_load = 1'b0;
  endtask

  task automatic set_cfg(input logic [15:0] l, input logic [15:0] r, input logic m);
    int f, la, ri, c, o, pc, pl;
    ext_l = {4{l}};
    ext_r = {4{r}};
    mode  = {4{m}};
    run_ch0(6, '0, 1, f, la, ri, c, o, pc, pl);
  endtask

  task automatic test_reset();
    int f, la, ri, c, o, pc, pl;
    logic [255:0] p;
    rst = 1'b0; pulse_in = '0; ext_l = '0; ext_r = '0; mode = '0; cfg_load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pulse_out !== 4'h0) $display("FAIL reset_out got=%h exp=0", pulse_out); else passed++;
    checks++; if (cfg_pending !== 4'h0) $display("FAIL reset_pend got=%h exp=0", cfg_pending); else passed++;
    @(negedge clk) rst = 1'b1;
    step();
    // Defaults L=0, R=0: tap at DLY, so a 1-cycle pulse at 10 appears only at 75
    p = '0; p[10] = 1'b1;
    run_ch0(90, p, -1, f, la, ri, c, o, pc, pl);
    checks++; if (f !== 75) $display("FAIL def_first got=%0d exp=75", f); else passed++;
    checks++; if (c !== 1) $display("FAIL def_width got=%0d exp=1", c); else passed++;
  endtask

  task automatic test_cfg_idle();
    int f, la, ri, c, o, pc, pl;
    ext_l = {4{16'd10}}; ext_r = {4{16'd5}}; mode = 4'h0;
    run_ch0(8, '0, 2, f, la, ri, c, o, pc, pl);
    checks++; if (pc !== 1) $display("FAIL idle_pend_cycles got=%0d exp=1", pc); else passed++;
    checks++; if (pl !== 4) $display("FAIL idle_pend_clear got=%0d exp=4", pl); else passed++;
    checks++; if (f !== -1) $display("FAIL idle_no_out got=%0d exp=-1", f); else passed++;
  endtask

  task automatic test_basic();
    int f, la, ri, c, o, pc, pl;
    logic [255:0] p;
    p = '0; p[100] = 1'b1;
    run_ch0(200, p, -1, f, la, ri, c, o, pc, pl);
    checks++; if (f !== 155) $display("FAIL basic_first got=%0d exp=155", f); else passed++;
    checks++; if (la !== 170) $display("FAIL basic_last got=%0d exp=170", la); else passed++;
    checks++; if (c !== 16) $display("FAIL basic_width got=%0d exp=16", c); else passed++;
    checks++; if (o !== 0) $display("FAIL basic_others got=%0d exp=0", o); else passed++;
  endtask

  task automatic test_merge();
    int f, la, ri, c, o, pc, pl;
    logic [255:0] p;
    set_cfg(16'd0, 16'd3, 1'b0);
    // Each 1-cycle pulse gives a 4-cycle window; pulses 4 apart abut, 5 apart leave a gap
    p = '0; p[0] = 1'b1; p[4] = 1'b1;
    run_ch0(100, p, -1, f, la, ri, c, o, pc, pl);
    checks++; if (f !== 65) $display("FAIL merge_first got=%0d exp=65", f); else passed++;
    checks++; if (c !== 8) $display("FAIL merge_width got=%0d exp=8", c); else passed++;
    checks++; if (ri !== 1) $display("FAIL merge_rises got=%0d exp=1", ri); else passed++;
    p = '0; p[0] = 1'b1; p[5] = 1'b1;
    run_ch0(100, p, -1, f, la, ri, c, o, pc, pl);
    checks++; if (la !== 73) $display("FAIL gap_last got=%0d exp=73", la); else passed++;
    checks++; if (c !== 8) $display("FAIL gap_width got=%0d exp=8", c); else passed++;
    checks++; if (ri !== 2) $display("FAIL gap_rises got=%0d exp=2", ri); else passed++;
  endtask

  task automatic test_oneshot();
    int f, la, ri, c, o, pc, pl;
    logic [255:0] p;
    set_cfg(16'd2, 16'd4, 1'b1);
    p = '0;
    for (int i = 10; i < 30; i++) p[i] = 1'b1;
    run_ch0(120, p, -1, f, la, ri, c, o, pc, pl);
    checks++; if (f !== 73) $display("FAIL shot_first got=%0d exp=73", f); else passed++;
    checks++; if (c !== 7) $display("FAIL shot_width got=%0d exp=7", c); else passed++;
    checks++; if (ri !== 1) $display("FAIL shot_rises got=%0d exp=1", ri); else passed++;
    // Edge at 13 lands inside the window; edge at 18 hits the first idle cycle (80)
    p = '0; p[10] = 1'b1; p[13] = 1'b1; p[18] = 1'b1;
    run_ch0(120, p, -1, f, la, ri, c, o, pc, pl);
    checks++; if (la !== 87) $display("FAIL shot2_last got=%0d exp=87", la); else passed++;
    checks++; if (c !== 14) $display("FAIL shot2_width got=%0d exp=14", c); else passed++;
    checks++; if (ri !== 2) $display("FAIL shot2_rises got=%0d exp=2", ri); else passed++;
  endtask

  task automatic test_clamp();
    int f, la, ri, c, o, pc, pl;
    logic [255:0] p;
    set_cfg(16'd200, 16'd0, 1'b0);
    p = '0;
    for (int i = 10; i < 15; i++) p[i] = 1'b1;
    run_ch0(120, p, -1, f, la, ri, c, o, pc, pl);
    checks++; if (f !== 11) $display("FAIL clamp_first got=%0d exp=11", f); else passed++;
    checks++; if (c !== 69) $display("FAIL clamp_width got=%0d exp=69", c); else passed++;
    set_cfg(16'd64, 16'hFFFF, 1'b0);
    p = '0; p[10] = 1'b1;
    run_ch0(65620, p, -1, f, la, ri, c, o, pc, pl);
    checks++; if (f !== 11) $display("FAIL maxr_first got=%0d exp=11", f); else passed++;
    checks++; if (la !== 65610) $display("FAIL maxr_last got=%0d exp=65610", la); else passed++;
    checks++; if (c !== 65600) $display("FAIL maxr_width got=%0d exp=65600", c); else passed++;
  endtask

  task automatic test_shadow();
    int f, la, ri, c, o, pc, pl;
    logic [255:0] p;
    set_cfg(16'd10, 16'd5, 1'b0);
    ext_l = {4{16'd0}};
    p = '0; p[10] = 1'b1;
    run_ch0(120, p, 30, f, la, ri, c, o, pc, pl);
    checks++; if (f !== 65) $display("FAIL shadow_first got=%0d exp=65", f); else passed++;
    checks++; if (la !== 80) $display("FAIL shadow_last got=%0d exp=80", la); else passed++;
    checks++; if (pc !== 51) $display("FAIL shadow_pend_cycles got=%0d exp=51", pc); else passed++;
    checks++; if (pl !== 82) $display("FAIL shadow_pend_clear got=%0d exp=82", pl); else passed++;
    run_ch0(120, p, -1, f, la, ri, c, o, pc, pl);
    checks++; if (f !== 75) $display("FAIL newcfg_first got=%0d exp=75", f); else passed++;
    checks++; if (c !== 6) $display("FAIL newcfg_width got=%0d exp=6", c); else passed++;
  endtask

  task automatic test_reset_mid();
    int f, la, ri, c, o, pc, pl;
    logic [255:0] p;
    set_cfg(16'd10, 16'd5, 1'b0);
    ext_l = {4{16'd0}};
    for (int k = 0; k < 70; k++) begin
      pulse_in = {3'b000, k == 10};
      cfg_load = (k == 30);
      step();
    end
    pulse_in = '0; cfg_load = 1'b0;
    checks++; if (pulse_out[0] !== 1'b1) $display("FAIL pre_rst_out got=%b exp=1", pulse_out[0]); else passed++;
    checks++; if (cfg_pending[0] !== 1'b1) $display("FAIL pre_rst_pend got=%b exp=1", cfg_pending[0]); else passed++;
    #2 rst = 1'b0;
    #1;
    checks++; if (pulse_out !== 4'h0) $display("FAIL async_rst_out got=%h exp=0", pulse_out); else passed++;
    checks++; if (cfg_pending !== 4'h0) $display("FAIL async_rst_pend got=%h exp=0", cfg_pending); else passed++;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    step();
    p = '0; p[10] = 1'b1;
    run_ch0(100, p, -1, f, la, ri, c, o, pc, pl);
    checks++; if (f !== 75) $display("FAIL post_rst_first got=%0d exp=75", f); else passed++;
    checks++; if (c !== 1) $display("FAIL post_rst_width got=%0d exp=1", c); else passed++;
    checks++; if (pc !== 0) $display("FAIL post_rst_pend got=%0d exp=0", pc); else passed++;
  endtask

  initial begin
    test_reset();
    test_cfg_idle();
    test_basic();
    test_merge();
    test_oneshot();
    test_clamp();
    test_shadow();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
